// File: rtl/rgmii_rx_deframer.sv
// RGMII RX deframer: assembles 1G DDR bytes or 10/100 nibble pairs, strips preamble/SFD and
// emits one byte per beat on an AXI-stream master. Define RGMII_RX_FCS_CHECK_EN for FCS checking.
module rgmii_rx_deframer #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       speed_1g,
  input  logic [3:0] rgmii_rxd_rise,
  input  logic [3:0] rgmii_rxd_fall,
  input  logic       rgmii_rx_ctl_rise,
  input  logic       rgmii_rx_ctl_fall,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_frame_good,
  output logic       stat_frame_bad,
  output logic       stat_bad_sfd,
  output logic       stat_crc_err
);

  typedef enum logic [2:0] {StIdle, StPreamble, StPayload, StTrunc, StDrop} state_e;

  localparam logic [10:0] CntSat = 11'h7ff;
  localparam logic [10:0] MinLen = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_FRAME_LEN);

  state_e      state_q, state_d;
  logic        speed_q, speed_d, speed_eff;
  logic        phase_q, phase_d;
  logic [3:0]  lo_nib_q;
  logic        lo_er_q;
  logic        byte_stb, byte_dv, byte_er;
  logic [7:0]  byte_data;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic        err_q, err_d, end_err, crc_bad;
  logic [7:0]  tdata_d;
  logic        tvalid_d, tlast_d, tuser_d, good_d, bad_d, sfd_d, crc_err_d;

  // Speed follows the pin while idle and is frozen for the duration of a frame.
  assign speed_eff = (state_q == StIdle) ? speed_1g : speed_q;

  always_comb begin
    byte_stb  = 1'b0;
    byte_data = {rgmii_rxd_fall, rgmii_rxd_rise};
    byte_dv   = rgmii_rx_ctl_rise;
    byte_er   = rgmii_rx_ctl_rise ^ rgmii_rx_ctl_fall;
    phase_d   = phase_q;
    if (clk_en) begin
      if (speed_eff) begin
        byte_stb = 1'b1;
        phase_d  = 1'b0;
      end else if (phase_q) begin
        byte_stb  = 1'b1;
        byte_data = {rgmii_rxd_rise, lo_nib_q};
        byte_er   = byte_er | lo_er_q;
        phase_d   = 1'b0;
      end else if (rgmii_rx_ctl_rise) begin
        phase_d = 1'b1;
      end else begin
        // dv low on a low-nibble slot still reports end of carrier
        byte_stb = 1'b1;
      end
    end
  end

  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + 11'd1;

`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '1;
    end else if (state_q == StPreamble) begin
      crc_q <= '1;
    end else if (state_q == StPayload && byte_stb && byte_dv) begin
      crc_q <= crc32_byte(crc_q, byte_data);
    end
  end

  // Running CRC over data plus FCS lands on the fixed residue for a good frame.
  assign crc_bad = (crc_q != 32'hdebb20e3);
`else
  assign crc_bad = 1'b0;
`endif

  assign end_err = err_q | (cnt_q < MinLen) | crc_bad;

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tdata_d    = hold_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    sfd_d      = 1'b0;
    crc_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (byte_stb && byte_dv) begin
          state_d = StPreamble;
          speed_d = speed_1g;
        end
      end
      StPreamble: begin
        if (byte_stb) begin
          if (!byte_dv) begin
            state_d = StIdle;
          end else if (!byte_er && byte_data == 8'h55) begin
            state_d = StPreamble;
          end else if (!byte_er && byte_data == 8'hd5) begin
            state_d    = StPayload;
            cnt_d      = '0;
            hold_vld_d = 1'b0;
            err_d      = 1'b0;
          end else begin
            sfd_d   = 1'b1;
            state_d = StDrop;
          end
        end
      end
      StPayload: begin
        if (byte_stb) begin
          if (!byte_dv) begin
            state_d    = StIdle;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              tvalid_d  = 1'b1;
              tlast_d   = 1'b1;
              tuser_d   = end_err;
              good_d    = !end_err;
              bad_d     = end_err;
              crc_err_d = crc_bad;
            end else begin
              bad_d = 1'b1;
            end
          end else begin
            tvalid_d   = hold_vld_q;
            hold_d     = byte_data;
            hold_vld_d = 1'b1;
            cnt_d      = cnt_inc;
            err_d      = err_q | byte_er;
            if (cnt_inc == MaxLen) state_d = StTrunc;
          end
        end
      end
      StTrunc: begin
        tvalid_d   = 1'b1;
        tlast_d    = 1'b1;
        tuser_d    = 1'b1;
        bad_d      = 1'b1;
        hold_vld_d = 1'b0;
        state_d    = (byte_stb && !byte_dv) ? StIdle : StDrop;
      end
      StDrop: begin
        if (byte_stb && !byte_dv) state_d = StIdle;
      end
      default: state_d = StDrop;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StDrop;
      speed_q         <= 1'b1;
      phase_q         <= 1'b0;
      lo_nib_q        <= '0;
      lo_er_q         <= 1'b0;
      hold_q          <= '0;
      hold_vld_q      <= 1'b0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      stat_frame_good <= 1'b0;
      stat_frame_bad  <= 1'b0;
      stat_bad_sfd    <= 1'b0;
      stat_crc_err    <= 1'b0;
    end else begin
      state_q         <= state_d;
      speed_q         <= speed_d;
      phase_q         <= phase_d;
      if (clk_en && !speed_eff && !phase_q) begin
        lo_nib_q <= rgmii_rxd_rise;
        lo_er_q  <= rgmii_rx_ctl_rise ^ rgmii_rx_ctl_fall;
      end
      hold_q          <= hold_d;
      hold_vld_q      <= hold_vld_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      m_axis_tdata    <= tdata_d;
      m_axis_tvalid   <= tvalid_d;
      m_axis_tlast    <= tlast_d;
      m_axis_tuser    <= tuser_d;
      stat_frame_good <= good_d;
      stat_frame_bad  <= bad_d;
      stat_bad_sfd    <= sfd_d;
      stat_crc_err    <= crc_err_d;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Self-checking bench for rgmii_rx_deframer: table of frame scenarios, random frames against a
// frame-level reference model, and a mid-frame reset sequence.
module tb_rgmii_rx_deframer;

  localparam int MinLen = 64;
  localparam int MaxLen = 1518;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       speed_1g = 1'b1;
  logic [3:0] rxd_rise = '0;
  logic [3:0] rxd_fall = '0;
  logic       ctl_rise = 1'b0;
  logic       ctl_fall = 1'b0;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser, st_good, st_bad, st_sfd, st_crc;
  logic [14:0] outs;

  always #5 clk = ~clk;

  rgmii_rx_deframer #(.MIN_FRAME_LEN(MinLen), .MAX_FRAME_LEN(MaxLen)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .speed_1g(speed_1g),
    .rgmii_rxd_rise(rxd_rise), .rgmii_rxd_fall(rxd_fall),
    .rgmii_rx_ctl_rise(ctl_rise), .rgmii_rx_ctl_fall(ctl_fall),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .stat_frame_good(st_good), .stat_frame_bad(st_bad), .stat_bad_sfd(st_sfd),
    .stat_crc_err(st_crc)
  );

  assign outs = {tdata, tvalid, tlast, tuser, st_good, st_bad, st_sfd, st_crc};

  int checks = 0;
  int failures = 0;

  // Captured output stream
  logic [7:0] got_data[$];
  bit         got_last[$];
  bit         got_user[$];
  int         got_cyc[$];
  int n_good = 0, n_bad = 0, n_sfd = 0, n_crc = 0, n_orphan = 0, cyc = 0;

  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (tvalid) begin
      got_data.push_back(tdata);
      got_last.push_back(tlast);
      got_user.push_back(tuser);
      got_cyc.push_back(cyc);
    end
    if (st_good) n_good++;
    if (st_bad) n_bad++;
    if (st_sfd) n_sfd++;
    if (st_crc) n_crc++;
    if (tvalid && tlast && (int'(st_good) + int'(st_bad) != 1)) n_orphan++;
    if (!(tvalid && tlast) && st_good) n_orphan++;
    if (tvalid && !tlast && (st_good || st_bad)) n_orphan++;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Frame under test (bytes from first dv-high byte on) and per-byte error flags
  logic [7:0] fr_q[$];
  bit         er_q[$];
  // Model results
  logic [7:0] exp_q[$];
  bit exp_user;
  int exp_good, exp_bad, exp_sfd, exp_crc;

  function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    return r;
  endfunction

  // len counts bytes after SFD; frames of 4+ bytes end in an FCS over the preceding data
  task automatic build(input int n_pre, input logic [7:0] sfd, input int len, input int er_idx,
                       input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    int n_data, bit_pos;
    fr_q.delete();
    er_q.delete();
    for (int i = 0; i < n_pre; i++) fr_q.push_back(8'h55);
    fr_q.push_back(sfd);
    n_data = (len >= 4) ? len - 4 : len;
    c = '1;
    for (int i = 0; i < n_data; i++) begin
      b = 8'($urandom);
      fr_q.push_back(b);
      c = crc_update(c, b);
    end
    if (len >= 4) begin
      c = ~c;
      if (flip) begin
        bit_pos = $urandom_range(31, 0);
        c[bit_pos] = ~c[bit_pos];
      end
      fr_q.push_back(c[7:0]);
      fr_q.push_back(c[15:8]);
      fr_q.push_back(c[23:16]);
      fr_q.push_back(c[31:24]);
    end
    for (int i = 0; i < fr_q.size(); i++) er_q.push_back(1'b0);
    if (er_idx >= 0) er_q[n_pre + 1 + er_idx] = 1'b1;
  endtask

  // Frame-level expectation: preamble scan, payload slice, length/error/FCS rules
  task automatic model();
    int sfd_at, n;
    bit any_er, fcs_bad;
    logic [31:0] c, fcs;
    exp_q.delete();
    exp_user = 0; exp_good = 0; exp_bad = 0; exp_sfd = 0; exp_crc = 0;
    sfd_at = -1; any_er = 0; fcs_bad = 0;
    for (int i = 1; i < fr_q.size(); i++) begin
      if (er_q[i] || (fr_q[i] != 8'h55 && fr_q[i] != 8'hd5)) begin
        exp_sfd = 1;
        return;
      end
      if (fr_q[i] == 8'hd5) begin
        sfd_at = i;
        break;
      end
    end
    if (sfd_at < 0) return;
    n = fr_q.size() - sfd_at - 1;
    if (n == 0) begin
      exp_bad = 1;
      return;
    end
    if (n >= MaxLen) begin
      for (int i = 0; i < MaxLen; i++) exp_q.push_back(fr_q[sfd_at + 1 + i]);
      exp_user = 1;
      exp_bad = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(fr_q[sfd_at + 1 + i]);
      any_er |= er_q[sfd_at + 1 + i];
    end
`ifdef RGMII_RX_FCS_CHECK_EN
    fcs_bad = 1;
    if (n >= 4) begin
      c = '1;
      for (int i = 0; i < n - 4; i++) c = crc_update(c, exp_q[i]);
      fcs = {exp_q[n-1], exp_q[n-2], exp_q[n-3], exp_q[n-4]};
      fcs_bad = (~c != fcs);
    end
    exp_crc = int'(fcs_bad);
`endif
    exp_user = any_er || (n < MinLen) || fcs_bad;
    exp_good = exp_user ? 0 : 1;
    exp_bad  = exp_user ? 1 : 0;
  endtask

  task automatic nib_evt(input logic [3:0] n, input bit dv, input bit er);
    rxd_rise = n;
    rxd_fall = 4'($urandom);
    ctl_rise = dv;
    ctl_fall = dv ^ er;
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  // In nibble mode the error flag rides on the low nibble only, so stickiness is exercised
  task automatic byte_evt(input bit spd, input logic [7:0] b, input bit dv, input bit er);
    if (spd) begin
      rxd_rise = b[3:0];
      rxd_fall = b[7:4];
      ctl_rise = dv;
      ctl_fall = dv ^ er;
      clk_en = 1'b1;
      @(posedge clk); #1;
    end else begin
      nib_evt(b[3:0], dv, er);
      nib_evt(b[7:4], dv, 1'b0);
    end
  endtask

  task automatic drive_frame(input bit spd, input int rst_at);
    speed_1g = spd;
    repeat (3) byte_evt(spd, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < fr_q.size(); i++) begin
      if (i == rst_at) begin
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", int'(outs), 0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
      byte_evt(spd, fr_q[i], 1'b1, er_q[i]);
    end
    repeat (3) byte_evt(spd, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int b0, g0, bd0, s0, c0, o0;

  task automatic snap();
    b0 = got_data.size(); g0 = n_good; bd0 = n_bad; s0 = n_sfd; c0 = n_crc; o0 = n_orphan;
  endtask

  task automatic check_frame(input string tag, input bit spd, input int ebeats, input bit euser,
                             input int eg, input int eb, input int es, input int ec);
    int nb, mism, nlast, lastpos, gaps;
    nb = got_data.size() - b0;
    mism = 0; nlast = 0; lastpos = -1; gaps = 0;
    for (int i = 0; i < nb; i++) begin
      if (i >= exp_q.size() || got_data[b0 + i] != exp_q[i]) mism++;
      if (got_last[b0 + i]) begin
        nlast++;
        lastpos = i;
      end
      if (i > 0 && i < nb - 1 && got_cyc[b0 + i] - got_cyc[b0 + i - 1] != (spd ? 1 : 20)) gaps++;
    end
    check({tag, " beats"}, nb, ebeats);
    check({tag, " data_mismatches"}, mism, 0);
    check({tag, " tlast_count"}, nlast, (ebeats > 0) ? 1 : 0);
    check({tag, " tlast_pos"}, lastpos, ebeats - 1);
    check({tag, " beat_spacing_errs"}, gaps, 0);
    if (nb > 0) check({tag, " tuser"}, int'(got_user[got_user.size() - 1]), int'(euser));
    check({tag, " stat_good"}, n_good - g0, eg);
    check({tag, " stat_bad"}, n_bad - bd0, eb);
    check({tag, " stat_bad_sfd"}, n_sfd - s0, es);
    check({tag, " stat_crc_err"}, n_crc - c0, ec);
    check({tag, " stat_without_tlast"}, n_orphan - o0, 0);
  endtask

  typedef struct {
    bit         spd;
    int         n_pre;
    logic [7:0] sfd;
    int         len;
    int         er_idx;
    bit         flip;
    int         beats;
    bit         user;
    int         good;
    int         bad;
    int         bsfd;
    int         crc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 7, 8'hd5, 64, -1, 0, 64, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 7, 8'hd5, 64, -1, 0, 64, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 7, 8'hd5, 64, 20, 0, 64, 1, 0, 1, 0, 0};
    vecs[3]  = '{1, 2, 8'h5d, 10, -1, 0, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{1, 7, 8'hd5, 1600, -1, 0, 1518, 1, 0, 1, 0, 0};
`ifdef RGMII_RX_FCS_CHECK_EN
    vecs[5]  = '{1, 7, 8'hd5, 64, -1, 1, 64, 1, 0, 1, 0, 1};
`else
    vecs[5]  = '{1, 7, 8'hd5, 64, -1, 1, 64, 0, 1, 0, 0, 0};
`endif
    vecs[6]  = '{0, 7, 8'hd5, 20, -1, 0, 20, 1, 0, 1, 0, 0};
    vecs[7]  = '{0, 7, 8'hd5, 64, 5, 0, 64, 1, 0, 1, 0, 0};
    vecs[8]  = '{1, 7, 8'hd5, 0, -1, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{1, 7, 8'hd5, 1517, -1, 0, 1517, 0, 1, 0, 0, 0};
    vecs[10] = '{1, 7, 8'hd5, 1518, -1, 0, 1518, 1, 0, 1, 0, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", int'(outs), 0);

    for (int v = 0; v < 11; v++) begin
      build(vecs[v].n_pre, vecs[v].sfd, vecs[v].len, vecs[v].er_idx, vecs[v].flip);
      model();
      snap();
      drive_frame(vecs[v].spd, -1);
      check_frame($sformatf("vec%0d", v), vecs[v].spd, vecs[v].beats, vecs[v].user,
                  vecs[v].good, vecs[v].bad, vecs[v].bsfd, vecs[v].crc);
    end

    // Reset at payload byte 30: 28 beats already out, then silence until the next frame
    build(7, 8'hd5, 64, -1, 0);
    snap();
    drive_frame(1'b1, 8 + 29);
    check("rst_frame beats", got_data.size() - b0, 28);
    check("rst_frame no_tlast", (got_data.size() > 0) ? int'(got_last[got_last.size() - 1]) : 0, 0);
    check("rst_frame stats", (n_good - g0) + (n_bad - bd0) + (n_sfd - s0), 0);
    build(7, 8'hd5, 64, -1, 0);
    model();
    snap();
    drive_frame(1'b1, -1);
    check_frame("after_rst", 1'b1, 64, 1'b0, 1, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      bit spd, flip;
      int len, er_idx, n_pre;
      logic [7:0] sfd;
      spd = 1'($urandom_range(1, 0));
      len = $urandom_range(120, 5);
      er_idx = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
      flip = ($urandom_range(3, 0) == 0);
      n_pre = $urandom_range(7, 1);
      sfd = ($urandom_range(5, 0) == 0) ? 8'($urandom) : 8'hd5;
      build(n_pre, sfd, len, er_idx, flip);
      model();
      snap();
      drive_frame(spd, -1);
      check_frame($sformatf("rand%0d", r), spd, exp_q.size(), exp_user,
                  exp_good, exp_bad, exp_sfd, exp_crc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
